fp_mul_arbiter: RTL and testbench

FP_MUL_ARBITER -- requirements
Module: fp_mul_arbiter

---
 rtl/fp_mul_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_fp_mul_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_arbiter.sv
// Round-robin arbiter sharing one 32-bit FP multiplier among NUM_REQ requesters.
// Define FP_MUL_ARB_TIMEOUT_EN to build the WAIT-state watchdog.
module fp_mul_arbiter #(
  parameter  int unsigned NUM_REQ        = 4,
  parameter  int unsigned TIMEOUT_CYCLES = 15,
  localparam int unsigned DW             = 32,
  localparam int unsigned FW             = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid_i,
  input  logic [NUM_REQ*DW-1:0] req_a_i,
  input  logic [NUM_REQ*DW-1:0] req_b_i,
  output logic [NUM_REQ-1:0]    req_ready_o,
  output logic [NUM_REQ-1:0]    rsp_valid_o,
  input  logic [NUM_REQ-1:0]    rsp_ready_i,
  output logic [DW-1:0]         rsp_product_o,
  output logic [FW-1:0]         rsp_flags_o,
  output logic                  mul_start_o,
  output logic [DW-1:0]         mul_a_o,
  output logic [DW-1:0]         mul_b_o,
  input  logic [DW-1:0]         mul_product_i,
  input  logic                  mul_done_i,
  input  logic                  mul_nan_i,
  input  logic                  mul_infinit_i,
  input  logic                  mul_overflow_i,
  input  logic                  mul_underflow_i
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("fp_mul_arbiter: NUM_REQ must be in 2..8");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("fp_mul_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_e;

  state_e             state_q,     state_d;
  logic [IDX_W-1:0]   rr_ptr_q,    rr_ptr_d;
  logic [IDX_W-1:0]   grant_q,     grant_d;
  logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]      product_q,   product_d;
  logic [FW-1:0]      flags_q,     flags_d;
  logic               mul_start_q, mul_start_d;
  logic [DW-1:0]      mul_a_q,     mul_a_d;
  logic [DW-1:0]      mul_b_q,     mul_b_d;
  logic [FW-2:0]      sticky_q,    sticky_d;

`ifdef FP_MUL_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [DW-1:0] TIMEOUT_NAN = 32'h7FC0_0000;
  logic [CNT_W-1:0]   cnt_q,       cnt_d;
`endif

  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic [FW-2:0]      flag_in;
  logic [FW-2:0]      sticky_now;

  function automatic logic [IDX_W-1:0] wrap_idx(input int unsigned v);
    return (v >= NUM_REQ) ? IDX_W'(v - NUM_REQ) : IDX_W'(v);
  endfunction

  assign flag_in    = {mul_nan_i, mul_infinit_i, mul_overflow_i, mul_underflow_i};
  assign sticky_now = sticky_q | flag_in;

  // First valid requester at or after rr_ptr, wrapping
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!pick_found && req_valid_i[wrap_idx(32'(rr_ptr_q) + i)]) begin
        pick_found = 1'b1;
        pick_idx   = wrap_idx(32'(rr_ptr_q) + i);
      end
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    req_ready_d = '0;
    rsp_valid_d = '0;
    product_d   = product_q;
    flags_d     = flags_q;
    mul_start_d = 1'b0;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    sticky_d    = sticky_q;
`ifdef FP_MUL_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          req_ready_d[pick_idx] = 1'b1;
          grant_d               = pick_idx;
          rr_ptr_d              = wrap_idx(32'(pick_idx) + 32'd1);
          mul_a_d               = req_a_i[DW*pick_idx +: DW];
          mul_b_d               = req_b_i[DW*pick_idx +: DW];
          state_d               = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        mul_start_d = 1'b1;
        sticky_d    = '0;
`ifdef FP_MUL_ARB_TIMEOUT_EN
        cnt_d       = '0;
`endif
        state_d     = ST_WAIT;
      end

      ST_WAIT: begin
        // Flags lead done by a cycle or two, so accumulate them until done
        sticky_d = sticky_now;
        if (mul_done_i) begin
          product_d            = mul_product_i;
          flags_d              = {1'b0, sticky_now};
          rsp_valid_d[grant_q] = 1'b1;
          state_d              = ST_RESP;
        end
`ifdef FP_MUL_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          product_d            = TIMEOUT_NAN;
          flags_d              = {1'b1, sticky_now};
          rsp_valid_d[grant_q] = 1'b1;
          state_d              = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end

      ST_RESP: begin
        if (rsp_ready_i[grant_q]) begin
          state_d = ST_IDLE;
        end else begin
          rsp_valid_d = rsp_valid_q;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      product_q   <= '0;
      flags_q     <= '0;
      mul_start_q <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      sticky_q    <= '0;
`ifdef FP_MUL_ARB_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      product_q   <= product_d;
      flags_q     <= flags_d;
      mul_start_q <= mul_start_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      sticky_q    <= sticky_d;
`ifdef FP_MUL_ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign req_ready_o   = req_ready_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_product_o = product_q;
  assign rsp_flags_o   = flags_q;
  assign mul_start_o   = mul_start_q;
  assign mul_a_o       = mul_a_q;
  assign mul_b_o       = mul_b_q;

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Randomized self-checking bench for fp_mul_arbiter with a behavioural multiplier
// and a round-robin reference model.
module tb_fp_mul_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned TO = 15;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid_i, req_ready_o, rsp_valid_o, rsp_ready_i;
  logic [N*32-1:0]   req_a_i, req_b_i;
  logic [31:0]       rsp_product_o, mul_a_o, mul_b_o;
  logic [31:0]       mul_product_i = '0;
  logic [4:0]        rsp_flags_o;
  logic              mul_start_o, mul_done_i;
  logic              mul_nan_i, mul_infinit_i, mul_overflow_i, mul_underflow_i;

  logic              mdone      = 1'b0;
  logic              stray_done = 1'b0;
  logic [3:0]        mflags     = '0;
  logic [31:0]       a_m [N];
  logic [31:0]       b_m [N];
  logic [N-1:0]      pend;
  int                ptr_m;
  bit                hang;
  logic [3:0]        pat_early, pat_done;
  int                cyc = 0;
  int                mcnt = 0;
  int                checks = 0;
  int                errors = 0;

  assign mul_done_i = mdone | stray_done;
  assign {mul_nan_i, mul_infinit_i, mul_overflow_i, mul_underflow_i} = mflags;

  always_comb begin
    for (int k = 0; k < N; k++) begin
      req_a_i[32*k +: 32] = a_m[k];
      req_b_i[32*k +: 32] = b_m[k];
    end
  end

  fp_mul_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid_i    (req_valid_i),
    .req_a_i        (req_a_i),
    .req_b_i        (req_b_i),
    .req_ready_o    (req_ready_o),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_ready_i    (rsp_ready_i),
    .rsp_product_o  (rsp_product_o),
    .rsp_flags_o    (rsp_flags_o),
    .mul_start_o    (mul_start_o),
    .mul_a_o        (mul_a_o),
    .mul_b_o        (mul_b_o),
    .mul_product_i  (mul_product_i),
    .mul_done_i     (mul_done_i),
    .mul_nan_i      (mul_nan_i),
    .mul_infinit_i  (mul_infinit_i),
    .mul_overflow_i (mul_overflow_i),
    .mul_underflow_i(mul_underflow_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] mul_ref(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h4000_0000 && b == 32'h4040_0000) return 32'h40C0_0000;
    return (a ^ {b[15:0], b[31:16]}) + 32'h0000_1357;
  endfunction

  function automatic int rr_pick(input logic [N-1:0] p, input int ptr);
    for (int i = 0; i < N; i++) begin
      if (p[(ptr + i) % N]) return (ptr + i) % N;
    end
    return 0;
  endfunction

  function automatic logic [N-1:0] onehot(input int k);
    logic [N-1:0] v;
    v    = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  // Multiplier model: flags at cycle 2 and 4 after start's cycle 1, done at cycle 4
  always @(negedge clk) begin
    if (rst) begin
      mcnt   = 0;
      mdone  = 1'b0;
      mflags = '0;
    end else begin
      mdone  = 1'b0;
      mflags = '0;
      if (mul_start_o) mcnt = 1;
      else if (mcnt != 0) mcnt++;
      if (mcnt == 2) mflags = pat_early;
      if (mcnt == 4) begin
        mflags        = pat_done;
        mul_product_i = mul_ref(mul_a_o, mul_b_o);
        if (!hang) begin
          mdone = 1'b1;
          mcnt  = 0;
        end
      end
    end
  end

  // One full transaction against the reference; caller has driven req_valid_i at a negedge
  task automatic do_txn(input int unsigned hold, output int got);
    int n, g, t0;
    logic [31:0] ep;
    logic [4:0]  ef;
    logic [N-1:0] oh;
    bit stable, spur;
    got = -1;
    n = 0;
    do begin @(negedge clk); n++; end while (req_ready_o == '0 && n < 50);
    check("grant_seen", 32'(|req_ready_o), 32'd1);
    if (req_ready_o == '0) return;
    g  = rr_pick(pend, ptr_m);
    oh = onehot(g);
    check("grant", 32'(req_ready_o), 32'(oh));
    for (int k = 0; k < N; k++) if (req_ready_o[k]) got = k;
    t0      = cyc;
    pend[g] = 1'b0;
    req_valid_i = pend;
    ptr_m   = (g + 1) % N;
    ep = hang ? 32'h7FC0_0000 : mul_ref(a_m[g], b_m[g]);
    ef = {hang, pat_early | pat_done};

    @(negedge clk);
    check("start", 32'(mul_start_o), 32'd1);
    check("mul_a", mul_a_o, a_m[g]);
    check("mul_b", mul_b_o, b_m[g]);
    spur = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      spur |= (req_ready_o != '0) || (rsp_valid_o == '0 && mul_start_o);
    end while (rsp_valid_o == '0 && n < 40);
    check("latency", 32'(cyc - t0), hang ? 32'(TO + 1) : 32'd5);
    check("rsp_valid", 32'(rsp_valid_o), 32'(oh));
    check("product", rsp_product_o, ep);
    check("flags", 32'(rsp_flags_o), 32'(ef));

    stable = 1'b1;
    for (int i = 0; i < int'(hold); i++) begin
      rsp_ready_i = N'($urandom) & ~oh;
      stray_done  = 1'($urandom);
      @(negedge clk);
      stable &= (rsp_valid_o == oh) && (rsp_product_o == ep) && (rsp_flags_o == ef);
      spur   |= (req_ready_o != '0) || mul_start_o;
    end
    rsp_ready_i = oh;
    stray_done  = 1'b0;
    @(negedge clk);
    rsp_ready_i = '0;
    check("hold_stable", 32'(stable), 32'd1);
    check("busy_quiet", 32'(spur), 32'd0);
    check("rsp_drop", 32'(rsp_valid_o), 32'd0);
    check("rsp_keep", rsp_product_o, ep);
  endtask

  function automatic logic [31:0] outs_or();
    return 32'(|{req_ready_o, rsp_valid_o, rsp_product_o, rsp_flags_o, mul_start_o, mul_a_o, mul_b_o});
  endfunction

  initial begin
    int got, n;
    rst = 1'b1; req_valid_i = '0; rsp_ready_i = '0; pend = '0; ptr_m = 0;
    hang = 1'b0; pat_early = '0; pat_done = '0;
    for (int k = 0; k < N; k++) begin a_m[k] = $urandom; b_m[k] = $urandom; end
    repeat (3) @(negedge clk);
    check("reset_outs", outs_or(), 32'd0);
    rst = 1'b0;

    // Three simultaneous requests, then wrap-around back to requester 0
    pend = 4'b1101; req_valid_i = pend;
    do_txn(2, got); check("order_first", 32'(got), 32'd0);
    do_txn(0, got); check("order_second", 32'(got), 32'd2);
    pend[0] = 1'b1; req_valid_i = pend;
    do_txn(1, got); check("order_third", 32'(got), 32'd3);
    do_txn(0, got); check("order_wrap", 32'(got), 32'd0);

    // 2.0 x 3.0 from requester 1
    a_m[1] = 32'h4000_0000; b_m[1] = 32'h4040_0000;
    pend = 4'b0010; req_valid_i = pend;
    do_txn(0, got);
    check("dir_product", rsp_product_o, 32'h40C0_0000);

    // NaN flag pulsed two cycles before done
    a_m[2] = 32'h7FC0_0000; b_m[2] = 32'h4000_0000; pat_early = 4'b1000;
    pend = 4'b0100; req_valid_i = pend;
    do_txn(0, got);
    check("nan_flags", 32'(rsp_flags_o), 32'h08);
    pat_early = '0;

    // Flags raised in the same cycle as done
    pat_done = 4'b0011;
    pend = 4'b1000; req_valid_i = pend;
    do_txn(0, got);
    check("late_flags", 32'(rsp_flags_o), 32'h03);
    pat_done = '0;

    // Sticky flags must not leak into the next operation
    pend = 4'b0001; req_valid_i = pend;
    do_txn(0, got);
    check("flags_clear", 32'(rsp_flags_o), 32'h00);

    // Long response stall while another requester waits
    pend = 4'b0011; req_valid_i = pend;
    do_txn(10, got); check("stall_grant", 32'(got), 32'd1);
    do_txn(0, got);  check("after_stall", 32'(got), 32'd0);

    // Reset while waiting on the multiplier
    pend = 4'b0100; req_valid_i = pend;
    n = 0;
    do begin @(negedge clk); n++; end while (req_ready_o == '0 && n < 50);
    check("abort_grant", 32'(req_ready_o), 32'h4);
    pend = '0; req_valid_i = pend;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_outs", outs_or(), 32'd0);
    n = 0;
    repeat (3) begin @(negedge clk); n += int'(|rsp_valid_o); end
    check("rst_no_rsp", 32'(n), 32'd0);
    rst = 1'b0; ptr_m = 0;
    pend = 4'b1110; req_valid_i = pend;
    n = 0;
    repeat (6) begin @(negedge clk); n += int'(|rsp_valid_o); if (req_ready_o != '0) break; end
    check("abort_silent", 32'(n), 32'd0);
    // grant already observed in loop above: verify against the reference and finish the txn
    check("post_rst_grant", 32'(req_ready_o), 32'(onehot(rr_pick(pend, ptr_m))));
    pend[rr_pick(pend, ptr_m)] = 1'b0; req_valid_i = pend; ptr_m = 2;
    repeat (4) @(negedge clk);
    n = 0;
    while (rsp_valid_o == '0 && n < 20) begin @(negedge clk); n++; end
    check("post_rst_rsp", 32'(rsp_valid_o), 32'h2);
    rsp_ready_i = 4'b0010;
    @(negedge clk);
    rsp_ready_i = '0;

`ifdef FP_MUL_ARB_TIMEOUT_EN
    // Multiplier never finishes: watchdog response
    hang = 1'b1;
    req_valid_i = pend;
    do_txn(0, got);
    check("to_product", rsp_product_o, 32'h7FC0_0000);
    check("to_flags", 32'(rsp_flags_o), 32'h10);
    hang = 1'b0;
`endif

    // Randomized traffic
    for (int it = 0; it < 30; it++) begin
      for (int k = 0; k < N; k++) begin
        if (!pend[k] && $urandom_range(0, 1) == 1) begin
          a_m[k] = $urandom; b_m[k] = $urandom; pend[k] = 1'b1;
        end
      end
      if (pend == '0) pend[$urandom_range(0, N-1)] = 1'b1;
      pat_early = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
      pat_done  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      req_valid_i = pend;
      do_txn($urandom_range(0, 3), got);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
